// File: rtl/serial_tx_if.sv
// Byte handshake between a byte producer (message_printer) and serial_tx.
// The producer drives data/strobe/flow-control; the transmitter answers with busy.
interface serial_tx_if;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;
    logic       block;

    modport master (
        output tx_data,
        output new_tx_data,
        output block,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  new_tx_data,
        input  block,
        output tx_busy
    );
endinterface

// File: rtl/serial_tx.sv
// Byte-wide UART transmitter, 8N1 by default; define SERIAL_TX_PARITY_EN for 8E1.
// tx is registered so the line never glitches; tx_busy also reflects downstream block.
//
// state  | meaning
// -------+----------------------------------------------------
// IDLE   | line high, waiting for new_tx_data with block low
// START  | start bit (low) for CLK_PER_BIT cycles
// DATA   | data bits, LSB first, one bit time each
// PARITY | even parity over the latched byte (parity build only)
// STOP   | stop bit (high) for CLK_PER_BIT cycles
module serial_tx #(
    parameter int CLK_PER_BIT = 50
) (
    input  logic       clk,
    input  logic       rst,
    serial_tx_if.slave bus,
    output logic       tx
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef SERIAL_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          bit_end;

    assign bit_end     = (cnt == CNT_LAST);
    assign bus.tx_busy = (state != IDLE) | bus.block;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            tx    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (bus.new_tx_data && !bus.block) begin
                        shift <= bus.tx_data;
                        cnt   <= '0;
                        idx   <= '0;
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= DATA;
                        tx    <= shift[0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= ^shift;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                            tx  <= shift[idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    // tx already high; back in IDLE one cycle before the next accept
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: expected line and busy waveforms are built per cycle from
// the frame rules (start, LSB-first data, optional even parity, stop) and compared each cycle.
`timescale 1ns/1ps
module tb_serial_tx;
    localparam int C = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx;
    int   total = 0;
    int   bad = 0;
    logic exp_tx[$];
    logic exp_busy[$];

    serial_tx_if bus();

    serial_tx #(.CLK_PER_BIT(C)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .tx (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic void push_frame(input logic [7:0] b);
        int v = int'(b);
        int ones = 0;
        int bits[$];
        bits.push_back(0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back(v % 2);
            ones += v % 2;
            v = v / 2;
        end
        if (NB == 11) bits.push_back(ones % 2);
        bits.push_back(1);
        foreach (bits[k]) begin
            for (int r = 0; r < C; r++) begin
                exp_tx.push_back(bits[k] != 0);
                exp_busy.push_back(1'b1);
            end
        end
    endfunction

    function automatic void push_idle(input int n, input logic busy);
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(1'b1);
            exp_busy.push_back(busy);
        end
    endfunction

    // Sample n cycles on the falling edge against the head of the expected queues.
    task automatic step_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s tx", tag), tx, exp_tx.pop_front());
            check($sformatf("%s busy", tag), bus.tx_busy, exp_busy.pop_front());
        end
    endtask

    // Called just after a falling edge with the DUT idle; poke>0 adds an ignored 0xFF request.
    task automatic send_byte(input logic [7:0] b, input int poke);
        string tag = $sformatf("frame_%02h", b);
        bus.tx_data     = b;
        bus.new_tx_data = 1'b1;
        push_frame(b);
        push_idle(4, 1'b0);
        step_check(tag, 1);
        bus.new_tx_data = 1'b0;
        bus.tx_data     = 8'($urandom);
        if (poke > 0) begin
            step_check(tag, poke);
            bus.tx_data     = 8'hFF;
            bus.new_tx_data = 1'b1;
            step_check(tag, 1);
            bus.new_tx_data = 1'b0;
        end
        step_check(tag, exp_tx.size());
    endtask

    initial begin
        bus.tx_data     = 8'h00;
        bus.new_tx_data = 1'b0;
        bus.block       = 1'b0;

        // reset held with random request activity
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.tx_data     = 8'($urandom);
            bus.new_tx_data = 1'($urandom);
        end
        #1;
        check("reset tx", tx, 1'b1);
        check("reset busy", bus.tx_busy, 1'b0);
        @(negedge clk);
        rst             = 1'b1;
        bus.new_tx_data = 1'b0;
        push_idle(20, 1'b0);
        step_check("idle", 20);

        send_byte(8'h41, 0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), $urandom_range(NB * C - 4, 1));
        send_byte(8'h31, 0);
        send_byte(8'h30, 0);

        // held request, second byte queued by the driver: next start 10*C+1 (11*C+1) later
        bus.tx_data     = 8'h31;
        bus.new_tx_data = 1'b1;
        push_frame(8'h31);
        push_idle(1, 1'b0);
        push_frame(8'h30);
        push_idle(4, 1'b0);
        step_check("b2b", 1);
        bus.tx_data = 8'h30;
        step_check("b2b", NB * C + 1);
        bus.new_tx_data = 1'b0;
        step_check("b2b", exp_tx.size());

        // block raised during bit 3; pending request waits for block to drop
        bus.tx_data     = 8'h55;
        bus.new_tx_data = 1'b1;
        push_frame(8'h55);
        push_idle(6, 1'b1);
        step_check("flow", 1);
        bus.new_tx_data = 1'b0;
        step_check("flow", 4 * C + 1);
        bus.block = 1'b1;
        step_check("flow", NB * C - 4 * C + 1);
        bus.tx_data     = 8'hA3;
        bus.new_tx_data = 1'b1;
        step_check("flow", 3);
        bus.block = 1'b0;
        push_frame(8'hA3);
        push_idle(4, 1'b0);
        step_check("flow", 1);
        bus.new_tx_data = 1'b0;
        step_check("flow", exp_tx.size());

        // reset during bit 5 of 0x00
        bus.tx_data     = 8'h00;
        bus.new_tx_data = 1'b1;
        push_frame(8'h00);
        step_check("rstmid", 1);
        bus.new_tx_data = 1'b0;
        step_check("rstmid", 6 * C + 1);
        exp_tx.delete();
        exp_busy.delete();
        #2 rst = 1'b0;
        #1;
        check("rstmid async tx", tx, 1'b1);
        check("rstmid async busy", bus.tx_busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        push_idle(20, 1'b0);
        step_check("post_rst idle", 20);
        send_byte(8'hC6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_tx.md
# serial_tx

Byte-wide UART transmitter, the serial end of the `tx_data`/`new_tx_data`/`tx_busy` handshake driven by `message_printer`. It accepts one byte per handshake and shifts it out on a single line as 8N1 (start bit, 8 data bits LSB first, one stop bit) at a fixed clocks-per-bit rate. `tx_busy` provides backpressure to the byte producer. A `block` input lets a downstream flow-control source hold off new frames.

## Interface
- `CLK_PER_BIT`, default 50: clock cycles per serial bit (50 MHz clock / 1 Mbaud). Legal range is 2 or more. Counter width is `$clog2(CLK_PER_BIT)`.

Ports:
- `clk`, input, 1: single clock; everything samples on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `tx_data`, input, 8: byte to send; sampled only on an accept edge.
- `new_tx_data`, input, 1: request strobe; a one-cycle pulse or a held level are both legal.
- `tx_busy`, output, 1: high while a frame is in progress or while `block` is held.
- `block`, input, 1: when high in IDLE, no new frame starts.
- `tx`, output, 1: serial line; idles high.

## Operation
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- **IDLE:** `tx`=1. If `new_tx_data`=1 and `block`=0 on an edge (an accept edge):
  - latch `tx_data` into the shift register;
  - clear the bit-time counter and the bit index;
  - go to START.
- **START:** `tx`=0 for `CLK_PER_BIT` cycles, then go to DATA.
- **DATA:** `tx` = shift[bit index], LSB first. Each bit is held for `CLK_PER_BIT` cycles. After bit 7, go to PARITY if compiled in, otherwise STOP.
- **PARITY:** `tx` = XOR of the latched byte (even parity), held for `CLK_PER_BIT` cycles, then go to STOP.
- **STOP:** `tx`=1 for `CLK_PER_BIT` cycles, then go to IDLE.
- `tx_busy` = (state != IDLE) | `block`. It is combinational from registered state and the `block` input.
- `new_tx_data` while not in IDLE is ignored. It is not queued.
- `tx_data` changes after the accept edge do not affect the frame in flight.
- `block` rising mid-frame does not stop the frame. The current frame completes; the next frame waits until `block`=0.
- Bit-time counter: counts 0..`CLK_PER_BIT`-1 and wraps to 0 on each bit boundary. The bit index advances only on that wrap.
- Reset (async, `rst`=0), at any time including mid-frame:
  - state goes to IDLE and `tx`=1 immediately;
  - counters and the shift register are cleared;
  - `tx_busy` = `block` (0 with `block` low).
  - No partial frame resumes after reset is released.

## Timing
- Let E0 be the accept edge. After E0, `tx`=0 and `tx_busy`=1.
- Data bit i is on the line from E0+(1+i)·C to E0+(2+i)·C, where C = `CLK_PER_BIT`.
- The stop bit starts at E0+9·C (E0+10·C with parity).
- The FSM re-enters IDLE at E0+10·C (E0+11·C with parity). `tx_busy` falls after that edge.
- The earliest next accept edge is E0+10·C+1. Back-to-back frame period is therefore 10·C+1 cycles (11·C+1 with parity). `tx` stays 1 during the extra cycle.
- `tx` is driven from a register, so the line is glitch-free.

## Configuration
- `SERIAL_TX_PARITY_EN`:
  - Defined: frame is 8E1. The PARITY state exists and frames are 11 bit-times.
  - Undefined: frame is 8N1. PARITY is not compiled and frames are 10 bit-times.
- Port list and handshake are identical in both builds.

## Test plan
- **Reset:** `rst`=0 with random inputs. Required: `tx`=1 and `tx_busy`=0. Release reset, then idle 20 cycles. Required: `tx` remains 1.
- **Single byte:** `CLK_PER_BIT`=4, pulse `new_tx_data` with `tx_data`=0x41 ('A'). Required:
  - `tx` sequence per 4 cycles: 0 | 1,0,0,0,0,0,1,0 | 1;
  - `tx_busy` high for exactly 40 cycles.
- **Parity build:** with `SERIAL_TX_PARITY_EN`, send 0x31 ('1'). Required: parity bit = 1. Send 0x30 ('0'). Required: parity bit = 0. Each frame is 44 cycles.
- **Back-to-back and ignored request:** hold `new_tx_data`=1 with "10" (0x31, 0x30) sequenced by the driver. Required: the second start bit begins exactly 41 cycles after the first. A `new_tx_data` pulse mid-frame with 0xFF produces no extra frame.
- **Flow control:** assert `block` during bit 3 of 0x55.
  - Required: the frame completes correctly and `tx_busy` stays 1 after the stop bit.
  - A pending `new_tx_data` starts a frame only on the first edge after `block` drops.
- **Reset mid-frame:** pull `rst` low during bit 5 of 0x00. Required: `tx`=1 asynchronously. After release, `tx` stays 1 until a new request arrives.
